// File: rtl/imem_loader.sv
// Loads a big-endian byte stream (4-byte length header, then words) into instruction memory.
// A word is written one cycle after its 4th byte; in_ready drops while the final write is pending and in DONE.
module imem_loader #(
  parameter int D_SIZE = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              restart,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [D_SIZE-1:0] imem_wdata,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_cnt
);

  typedef enum logic [1:0] {HDR, LOAD, DONE} state_t;

  localparam logic [32:0]   MAX_LEN = 33'd1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [23:0]         asm_q, asm_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [D_SIZE-1:0]   wdata_q, wdata_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                rdy_q, rdy_d;

  logic                xfer;
  logic [31:0]         word;
  logic [ADDR_W:0]     cnt_next;

  always_comb begin
    xfer       = in_valid & rdy_q;
    word       = {asm_q, in_byte};
    cnt_next   = word_cnt_q + CNT_ONE;
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    asm_d      = asm_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    done_d     = done_q;
    err_d      = err_q;
    rdy_d      = rdy_q;

    case (state_q)
      HDR: begin
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = word[23:0];
          if (byte_cnt_q == 2'd3) begin
            if (word == 32'd0) begin
              state_d = DONE;
              done_d  = 1'b1;
              rdy_d   = 1'b0;
            end else if ({1'b0, word} > MAX_LEN) begin
              state_d = DONE;
              done_d  = 1'b1;
              err_d   = 1'b1;
              rdy_d   = 1'b0;
            end else begin
              state_d = LOAD;
              len_d   = word[ADDR_W:0];
            end
          end
        end
      end

      LOAD: begin
        // The count advances as the write is issued; a 4th byte can never coincide with we_q.
        if (we_q) begin
          word_cnt_d = cnt_next;
          if (cnt_next == len_q) begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
        if (xfer) begin
          byte_cnt_d = byte_cnt_q + 2'd1;
          asm_d      = word[23:0];
          if (byte_cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = word_cnt_q[ADDR_W-1:0];
            wdata_d = D_SIZE'(word);
            if (cnt_next == len_q) rdy_d = 1'b0;
          end
        end
      end

      DONE: begin
        if (restart) begin
          state_d    = HDR;
          byte_cnt_d = 2'd0;
          len_d      = '0;
          word_cnt_d = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          rdy_d      = 1'b1;
        end
      end

      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= HDR;
      byte_cnt_q <= 2'd0;
      asm_q      <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      asm_q      <= asm_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdy_q      <= rdy_d;
    end
  end

  assign in_ready   = rdy_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign load_done  = done_q;
  assign load_err   = err_q;
  assign word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scenario bench for imem_loader: expected writes (cycle, addr, data) are queued as bytes are driven.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        restart = 1'b0;
  logic        in_ready;
  logic        imem_we;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        load_done;
  logic        load_err;
  logic [10:0] word_cnt;

  always #5 clk = ~clk;

  imem_loader #(.D_SIZE(32), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(in_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .load_done(load_done),
    .load_err(load_err), .word_cnt(word_cnt)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          mon_en = 1'b0;
  wr_t         sb[$];
  logic [7:0]  stim[$];
  wr_t         mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Every write strobe must match the oldest queued expectation, including its cycle.
  always @(negedge clk) begin
    if (mon_en && imem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%h at cycle %0d, required no write", imem_addr, imem_wdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (imem_addr !== mon_e.addr || imem_wdata !== mon_e.data || cyc !== int'(mon_e.cyc)) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                   imem_addr, imem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.cyc);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; restart = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    checks++;
    if ({load_done, load_err, in_ready, word_cnt} !== {3'b001, 11'd0}) begin
      errors++;
      $display("FAIL reset_clears: done/err/rdy=%b%b%b cnt=%0d, required 001 cnt=0", load_done, load_err, in_ready, word_cnt);
    end
  endtask

  // Drives stim[] (header first); words 0..n_words-1 are expected to be written.
  task automatic send_stim(input bit toggle, input int n_words);
    int  nb;
    wr_t w;
    nb = stim.size();
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_byte  = stim[i];
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL in_ready_stream: byte %0d in_ready=%b, required 1", i, in_ready);
      end
      if ((i % 4) == 3 && i >= 4 && (i / 4 - 1) < n_words) begin
        w.cyc  = 32'(cyc + 1);
        w.addr = 10'(i / 4 - 1);
        w.data = {stim[i-3], stim[i-2], stim[i-1], stim[i]};
        sb.push_back(w);
      end
      if (toggle) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
    if (!toggle) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    stim.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_we, imem_addr, imem_wdata, load_done, load_err, in_ready, word_cnt} !== {1'b0, 10'd0, 32'd0, 3'b001, 11'd0}) begin
      errors++;
      $display("FAIL reset_state: we=%b addr=%0d wdata=%h done=%b err=%b rdy=%b cnt=%0d, required 0 0 0 0 0 1 0",
               imem_we, imem_addr, imem_wdata, load_done, load_err, in_ready, word_cnt);
    end
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    restart = 1'b1;
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
    send_stim(1'b0, 2);
    restart = 1'b0;
    checks++;
    if ({in_ready, load_done} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_final_pending: rdy=%b done=%b, required rdy=0 done=0", in_ready, load_done);
    end
    @(negedge clk);
    checks++;
    if ({load_done, load_err, imem_we, word_cnt} !== {3'b100, 11'd2}) begin
      errors++;
      $display("FAIL b2b_done: done=%b err=%b we=%b cnt=%0d, required 1 0 0 cnt=2", load_done, load_err, imem_we, word_cnt);
    end
    checks++;
    if (imem_addr !== 10'd1 || imem_wdata !== 32'h9ABCDEF0) begin
      errors++;
      $display("FAIL b2b_hold: addr=%0d wdata=%h, required 1 9abcdef0", imem_addr, imem_wdata);
    end
  endtask

  task automatic test_zero_len();
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_stim(1'b0, 0);
    checks++;
    if ({load_done, load_err, in_ready, word_cnt} !== {3'b100, 11'd0}) begin
      errors++;
      $display("FAIL zero_len: done=%b err=%b rdy=%b cnt=%0d, required 1 0 0 cnt=0", load_done, load_err, in_ready, word_cnt);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_overflow();
    do_reset();
    stim = '{8'h00, 8'h00, 8'h04, 8'h00};
    send_stim(1'b0, 0);
    checks++;
    if ({load_done, load_err, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL max_len_accepted: done=%b err=%b rdy=%b, required 0 0 1", load_done, load_err, in_ready);
    end
    do_reset();
    stim = '{8'h00, 8'h00, 8'h04, 8'h01};
    send_stim(1'b0, 0);
    checks++;
    if ({load_done, load_err, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL overflow: done=%b err=%b rdy=%b, required 1 1 0", load_done, load_err, in_ready);
    end
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_byte = 8'hA0 + 8'(i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if ({load_done, load_err, in_ready, word_cnt} !== {3'b110, 11'd0}) begin
      errors++;
      $display("FAIL done_ignores_stream: done=%b err=%b rdy=%b cnt=%0d, required 1 1 0 cnt=0", load_done, load_err, in_ready, word_cnt);
    end
  endtask

  task automatic test_gaps();
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    send_stim(1'b1, 1);
    @(negedge clk);
    checks++;
    if ({load_done, load_err, word_cnt} !== {2'b10, 11'd1}) begin
      errors++;
      $display("FAIL gaps_done: done=%b err=%b cnt=%0d, required 1 0 cnt=1", load_done, load_err, word_cnt);
    end
  endtask

  task automatic test_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    checks++;
    if ({load_done, load_err, in_ready, word_cnt} !== {3'b001, 11'd0}) begin
      errors++;
      $display("FAIL restart_clears: done=%b err=%b rdy=%b cnt=%0d, required 0 0 1 cnt=0", load_done, load_err, in_ready, word_cnt);
    end
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    send_stim(1'b0, 1);
    @(negedge clk);
    checks++;
    if ({load_done, word_cnt} !== {1'b1, 11'd1}) begin
      errors++;
      $display("FAIL restart_reload: done=%b cnt=%0d, required 1 cnt=1", load_done, word_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h03, 8'h11, 8'h22};
    send_stim(1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({load_done, in_ready, word_cnt} !== {2'b01, 11'd0}) begin
      errors++;
      $display("FAIL mid_reset: done=%b rdy=%b cnt=%0d, required 0 1 cnt=0", load_done, in_ready, word_cnt);
    end
    stim = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h55, 8'h66, 8'h77, 8'h88};
    send_stim(1'b0, 1);
    @(negedge clk);
    checks++;
    if ({load_done, load_err, word_cnt} !== {2'b10, 11'd1}) begin
      errors++;
      $display("FAIL mid_reset_reload: done=%b err=%b cnt=%0d, required 1 0 cnt=1", load_done, load_err, word_cnt);
    end
  endtask

  task automatic test_reset_drops_write();
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};
    send_stim(1'b0, 0);
    in_valid = 1'b1;
    in_byte  = 8'h04;
    reset    = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({imem_we, in_ready, word_cnt} !== {2'b01, 11'd0}) begin
      errors++;
      $display("FAIL reset_drops_write: we=%b rdy=%b cnt=%0d, required 0 1 cnt=0", imem_we, in_ready, word_cnt);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_zero_len();
    test_overflow();
    test_gaps();
    test_restart();
    test_reset_mid_load();
    test_reset_drops_write();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missing_writes: %0d expected writes never seen, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 The module SHALL have parameter D_SIZE, default 32, meaning instruction word width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 10, meaning instruction-memory word-address width (depth 2^ADDR_W words).
REQ-003 The module SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 The module SHALL have port reset  input  1  reset that is synchronous and active-high.
REQ-005 The module SHALL have port in_valid  input  1  byte-stream valid.
REQ-006 The module SHALL have port in_byte  input  8  byte-stream data.
REQ-007 The module SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both 1 on a rising edge.
REQ-008 The module SHALL have port restart  input  1  single-cycle request to reload from DONE.
REQ-009 The module SHALL have port imem_we  output  1  instruction-memory write strobe.
REQ-010 The module SHALL have port imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 The module SHALL have port imem_wdata  output  D_SIZE  instruction-memory write data.
REQ-012 The module SHALL have port load_done  output  1  program loaded; drives core valid and releases fetch.
REQ-013 The module SHALL have port load_err  output  1  header length exceeded memory depth.
REQ-014 The module SHALL have port word_cnt  output  ADDR_W+1  words written so far in the current load.

Function
REQ-015 The FSM SHALL have states HDR (collect 4-byte length), LOAD (collect and write words), and DONE.
REQ-016 Bytes SHALL assemble big-endian: the first byte of each 4-byte group goes to bits [31:24] and the fourth to bits [7:0].
REQ-017 A 2-bit byte counter SHALL advance on each transfer and wrap 3->0 on the fourth byte.
REQ-018 In HDR, the fourth byte SHALL latch length N (32 bits); next state is LOAD if 0 < N <= 2^ADDR_W, DONE with load_err=0 if N=0, and DONE with load_err=1 if N > 2^ADDR_W.
REQ-019 In LOAD, the cycle after the fourth byte's transfer SHALL present imem_we=1 for exactly one cycle, with imem_addr = word_cnt[ADDR_W-1:0] (before increment) and imem_wdata = the assembled word.
REQ-020 In the cycle imem_we=1, word_cnt SHALL increment by 1.
REQ-021 When word_cnt reaches N at that increment, the FSM SHALL enter DONE in the same cycle.
REQ-022 in_ready SHALL be 1 in HDR and in LOAD, except in the single cycle in which the final word's write is pending.
REQ-023 in_ready SHALL be 0 in DONE; stream data in DONE SHALL be ignored.
REQ-024 Transfer latency SHALL be: byte accepted in HDR/LOAD at edge k, and a complete word written at edge k+1.
REQ-025 Back-to-back bytes with in_valid held high SHALL sustain 1 byte/cycle.
REQ-026 Gaps (in_valid=0) SHALL hold all assembly state.
REQ-027 load_done SHALL be 1 exactly while in DONE; imem_we SHALL be 0 in DONE.
REQ-028 restart=1 in DONE SHALL return the FSM to HDR on the next edge, clearing word_cnt, the byte counter, load_err and load_done.
REQ-029 restart outside DONE SHALL be ignored.
REQ-030 imem_addr wrap SHALL be impossible, because N <= 2^ADDR_W is enforced by REQ-018.
REQ-031 imem_wdata and imem_addr SHALL hold their last values when imem_we=0.

Reset
REQ-032 reset=1 on an edge SHALL force state HDR, byte counter 0, N=0, word_cnt=0, imem_we=0, imem_addr=0, imem_wdata=0, load_done=0, load_err=0, and in_ready=1 after the edge.
REQ-033 Reset SHALL override restart and any in-flight transfer, including a pending imem write, which SHALL be dropped (imem_we=0).
REQ-034 Reset asserted mid-LOAD SHALL discard the partial word; the next bytes SHALL be treated as a new header.

Verification
REQ-035 The bench SHALL cover: header 00 00 00 02, then bytes 12 34 56 78 9A BC DE F0 back-to-back -> writes 0x12345678@0 and 0x9ABCDEF0@1 one cycle after the 4th and 8th bytes, then load_done=1 and word_cnt=2.
REQ-036 The bench SHALL cover: header 00 00 00 00 -> DONE one cycle later, load_done=1, load_err=0, no imem_we pulses.
REQ-037 The bench SHALL cover: header 00 00 04 01 (1025 > 1024) -> load_done=1, load_err=1, no writes, in_ready=0.
REQ-038 The bench SHALL cover: N=1 with in_valid toggling 1/0 each cycle -> single write of the correct word at addr 0, and byte order preserved across gaps.
REQ-039 The bench SHALL cover: reset pulsed after 6 bytes of an N=3 load, then a new header N=1 plus 4 bytes -> only one write at addr 0, and word_cnt=1.
REQ-040 The bench SHALL cover: in DONE, restart=1 for one cycle, then reload N=1 -> load_done drops the next cycle, and the new word is written at addr 0.
